// File: rtl/sm_addsub_pipe.sv
// Sign-magnitude fraction add/sub: 3-stage pipeline (convert, add, output), 1 op/cycle, full valid/ready back-pressure.
// Stalled stages hold their contents and empty stages still accept. Optional Lzc output is enabled by SM_ADDSUB_LZC_EN.
module sm_addsub_pipe #(
  parameter int N = 24
) (
  input  logic         Clock,
  input  logic         ResetN,
  input  logic         InValid,
  output logic         InReady,
  input  logic [N-1:0] FracA,
  input  logic         SignA,
  input  logic [N-1:0] FracB,
  input  logic         SignB,
  input  logic         Sub,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [N-1:0] Result,
  output logic         ResultSign,
  output logic         ccc,
  output logic         ccz,
  output logic         ccv,
  output logic         ccn
`ifdef SM_ADDSUB_LZC_EN
  ,
  output logic [$clog2(N+2)-1:0] Lzc
`endif
);
  localparam int OPW = N + 2;
  localparam int LZW = $clog2(N + 2);

  logic           adv1, adv2, adv3;

  logic           v1_q, v1_d;
  logic [OPW-1:0] opa_q, opa_d, opb_q, opb_d;
  logic           sa1_q, sa1_d, esub1_q, esub1_d;

  logic           v2_q, v2_d;
  logic [OPW-1:0] sum_q, sum_d;
  logic           sa2_q, sa2_d, esub2_q, esub2_d;

  logic           v3_q, v3_d;
  logic [N-1:0]   res_q, res_d;
  logic           rsign_q, rsign_d, c_q, c_d, z_q, z_d, vf_q, vf_d;

  logic           eff_sb;
  logic [OPW-1:0] ext_a, ext_b;
  logic [N:0]     mag;
  logic           mag_z, rsign_w;

  always_comb begin
    adv3 = !v3_q || OutReady;
    adv2 = !v2_q || adv3;
    adv1 = !v1_q || adv2;
  end

  assign InReady = adv1;

  // S1: convert both operands to two's complement
  always_comb begin
    eff_sb  = SignB ^ Sub;
    ext_a   = {2'b00, FracA};
    ext_b   = {2'b00, FracB};
    v1_d    = v1_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sa1_d   = sa1_q;
    esub1_d = esub1_q;
    if (adv1) begin
      v1_d = InValid;
      if (InValid) begin
        opa_d   = SignA  ? (~ext_a + OPW'(1)) : ext_a;
        opb_d   = eff_sb ? (~ext_b + OPW'(1)) : ext_b;
        sa1_d   = SignA;
        esub1_d = SignA ^ eff_sb;
      end
    end
  end

  // S2: add; OPW bits are enough for the worst-case magnitude
  always_comb begin
    v2_d    = v2_q;
    sum_d   = sum_q;
    sa2_d   = sa2_q;
    esub2_d = esub2_q;
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        sum_d   = opa_q + opb_q;
        sa2_d   = sa1_q;
        esub2_d = esub1_q;
      end
    end
  end

  // S3: low N+1 bits of |sum|, conditional invert plus one
  always_comb begin
    mag     = (sum_q[N:0] ^ {(N+1){sum_q[OPW-1]}}) + {{N{1'b0}}, sum_q[OPW-1]};
    mag_z   = (mag == '0);
    rsign_w = sum_q[OPW-1] && !mag_z;
    v3_d    = v3_q;
    res_d   = res_q;
    rsign_d = rsign_q;
    c_d     = c_q;
    z_d     = z_q;
    vf_d    = vf_q;
    if (adv3) begin
      v3_d = v2_q;
      if (v2_q) begin
        res_d   = mag[N-1:0];
        rsign_d = rsign_w;
        c_d     = mag[N];
        z_d     = mag_z;
        vf_d    = esub2_q && (rsign_w != sa2_q) && !mag_z;
      end
    end
  end

`ifdef SM_ADDSUB_LZC_EN
  logic [LZW-1:0] lzc_q, lzc_d, lzc_w;

  always_comb begin
    lzc_w = LZW'(N + 1);
    for (int i = 0; i <= N; i++) begin
      if (mag[i]) lzc_w = LZW'(N - i);
    end
    lzc_d = lzc_q;
    if (adv3 && v2_q) lzc_d = lzc_w;
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) lzc_q <= '0;
    else         lzc_q <= lzc_d;
  end

  assign Lzc = lzc_q;
`endif

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      v1_q    <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sa1_q   <= 1'b0;
      esub1_q <= 1'b0;
      v2_q    <= 1'b0;
      sum_q   <= '0;
      sa2_q   <= 1'b0;
      esub2_q <= 1'b0;
      v3_q    <= 1'b0;
      res_q   <= '0;
      rsign_q <= 1'b0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      vf_q    <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sa1_q   <= sa1_d;
      esub1_q <= esub1_d;
      v2_q    <= v2_d;
      sum_q   <= sum_d;
      sa2_q   <= sa2_d;
      esub2_q <= esub2_d;
      v3_q    <= v3_d;
      res_q   <= res_d;
      rsign_q <= rsign_d;
      c_q     <= c_d;
      z_q     <= z_d;
      vf_q    <= vf_d;
    end
  end

  assign OutValid   = v3_q;
  assign Result     = res_q;
  assign ResultSign = rsign_q;
  assign ccc        = c_q;
  assign ccz        = z_q;
  assign ccv        = vf_q;
  assign ccn        = rsign_q;
endmodule
